// File: rtl/systolic_feeder_pkg.sv
// rtl/systolic_feeder_pkg.sv - shared widths, tap count and FSM state type for the systolic feeder
package systolic_pkg;
   localparam int WORDLENGTH_DEF = 16;
   localparam int TAPS           = 8;
   localparam int IDX_W          = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/systolic_feeder_fifo.sv
// rtl/systolic_feeder_fifo.sv - pointer-based synchronous FIFO with occupancy, full and empty flags
module feeder_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     fill,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fill    = wr_q - rd_q;
   assign full    = (fill == (AW+1)'(DEPTH));
   assign empty   = (wr_q == rd_q);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (push_ok) wr_d = wr_q + (AW+1)'(1);
      if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - paced word sequencer for the systolic PE chain
// SYSTOLIC_FEEDER_STALL_EN: stall on underrun instead of emitting a zero word.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int WORDLENGTH = WORDLENGTH_DEF,
   parameter int DEPTH      = 8
) (
   input  logic                       clk30x,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [31:0]                timing,
   input  logic [WORDLENGTH-1:0]      in_word,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [WORDLENGTH-1:0]      outputword,
   output logic                       word_strobe,
   output logic [IDX_W-1:0]           wordIndex,
   output logic                       frame_start,
   output logic                       underrun,
   input  logic                       clr_underrun,
   output logic [$clog2(DEPTH):0]     fill
);
   state_t                state_q, state_d;
   logic [31:0]           count_q, count_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W-1:0]      nidx_q, nidx_d;
   logic [WORDLENGTH-1:0] out_q, out_d;
   logic                  strobe_q, strobe_d;
   logic                  frame_q, frame_d;
   logic                  underrun_q, underrun_d;

   logic                  full;
   logic                  empty;
   logic                  pop;
   logic [WORDLENGTH-1:0] head;

   feeder_fifo #(
      .WIDTH (WORDLENGTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk30x),
      .rst_n (reset),
      .push  (in_valid && in_ready),
      .din   (in_word),
      .pop   (pop),
      .dout  (head),
      .fill  (fill),
      .full  (full),
      .empty (empty)
   );

   assign in_ready    = !full;
   assign outputword  = out_q;
   assign word_strobe = strobe_q;
   assign wordIndex   = idx_q;
   assign frame_start = frame_q;
   assign underrun    = underrun_q;

   // nidx_q is the index the next fire will present, so RUN entry starts at 0.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      idx_d      = idx_q;
      nidx_d     = nidx_q;
      out_d      = out_q;
      strobe_d   = 1'b0;
      frame_d    = 1'b0;
      pop        = 1'b0;
      underrun_d = clr_underrun ? 1'b0 : underrun_q;

      case (state_q)
         IDLE: begin
            count_d = '0;
            if (enable) state_d = RUN;
         end
         RUN: begin
            if (!enable) begin
               state_d = IDLE;
               count_d = '0;
               idx_d   = '0;
               nidx_d  = '0;
            end else if (count_q >= timing) begin
               if (!empty) begin
                  pop      = 1'b1;
                  count_d  = '0;
                  out_d    = head;
                  strobe_d = 1'b1;
                  frame_d  = (nidx_q == '0);
                  idx_d    = nidx_q;
                  nidx_d   = nidx_q + IDX_W'(1);
               end else begin
                  underrun_d = 1'b1;
`ifdef SYSTOLIC_FEEDER_STALL_EN
                  count_d    = count_q;
`else
                  count_d    = '0;
                  out_d      = '0;
                  strobe_d   = 1'b1;
                  frame_d    = (nidx_q == '0);
                  idx_d      = nidx_q;
                  nidx_d     = nidx_q + IDX_W'(1);
`endif
               end
            end else begin
               count_d = count_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk30x or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         idx_q      <= '0;
         nidx_q     <= '0;
         out_q      <= '0;
         strobe_q   <= 1'b0;
         frame_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         nidx_q     <= nidx_d;
         out_q      <= out_d;
         strobe_q   <= strobe_d;
         frame_q    <= frame_d;
         underrun_q <= underrun_d;
      end
   end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed self-checking bench for systolic_feeder
module tb_systolic_feeder;
   logic        clk30x = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] timing;
   logic [15:0] in_word;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] outputword;
   logic        word_strobe;
   logic [2:0]  wordIndex;
   logic        frame_start;
   logic        underrun;
   logic        clr_underrun;
   logic [3:0]  fill;

   int checks = 0;
   int errors = 0;

   systolic_feeder #(.WORDLENGTH(16), .DEPTH(8)) dut (
      .clk30x       (clk30x),
      .reset        (reset),
      .enable       (enable),
      .timing       (timing),
      .in_word      (in_word),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .outputword   (outputword),
      .word_strobe  (word_strobe),
      .wordIndex    (wordIndex),
      .frame_start  (frame_start),
      .underrun     (underrun),
      .clr_underrun (clr_underrun),
      .fill         (fill)
   );

   always #5 clk30x = ~clk30x;

   task automatic step();
      @(posedge clk30x);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; timing = 32'd3; in_word = '0;
      in_valid = 1'b0; clr_underrun = 1'b0;
      step(); step();
      chk("rst_outputword", outputword, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_fill", fill, 0);
      chk("rst_strobe", word_strobe, 0);
      chk("rst_index", wordIndex, 0);
      chk("rst_underrun", underrun, 0);
      reset = 1'b1;

      // basic pacing, timing=3
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_word = 16'(16'h0011 + i);
         step();
      end
      in_valid = 1'b0;
      chk("pace_fill_full", fill, 8);
      chk("pace_ready_low", in_ready, 0);
      enable = 1'b1;
      step();
      for (int k = 0; k < 8; k++) begin
         step(); step(); step();
         chk("pace_gap_strobe", word_strobe, 0);
         step();
         chk("pace_strobe", word_strobe, 1);
         chk("pace_word", outputword, 32'(16'h0011 + k));
         chk("pace_index", wordIndex, k);
         chk("pace_frame", frame_start, (k == 0) ? 1 : 0);
      end
      chk("pace_fill_empty", fill, 0);
      chk("pace_ready_high", in_ready, 1);
      enable = 1'b0;
      step();
      chk("pace_stop_index", wordIndex, 0);

      // backpressure, timing=9
      timing = 32'd9;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_word = 16'(16'h0021 + i);
         step();
      end
      in_word = 16'h0029;
      step(); step();
      chk("bp_fill", fill, 8);
      chk("bp_ready", in_ready, 0);
      enable = 1'b1;
      step();
      repeat (9) step();
      chk("bp_pre_strobe", word_strobe, 0);
      step();
      chk("bp_strobe", word_strobe, 1);
      chk("bp_word", outputword, 16'h0021);
      chk("bp_index", wordIndex, 0);
      chk("bp_fill_pop", fill, 7);
      chk("bp_ready_pop", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("bp_ninth_in", fill, 8);
      enable = 1'b0;
      step();
      chk("stop_index", wordIndex, 0);
      chk("stop_fill_kept", fill, 8);

      // timing drop mid-slot
      timing = 32'd20;
      enable = 1'b1;
      step();
      repeat (10) step();
      chk("drop_pre_strobe", word_strobe, 0);
      timing = 32'd2;
      step();
      chk("drop_strobe", word_strobe, 1);
      chk("drop_word", outputword, 16'h0022);
      chk("drop_index", wordIndex, 0);
      chk("drop_frame", frame_start, 1);
      chk("drop_fill", fill, 7);

      // asynchronous reset between edges
      step();
      #3;
      reset = 1'b0;
      #1;
      chk("areset_word", outputword, 0);
      chk("areset_index", wordIndex, 0);
      chk("areset_fill", fill, 0);
      chk("areset_ready", in_ready, 1);
      chk("areset_strobe", word_strobe, 0);
      enable = 1'b0;
      step();
      reset = 1'b1;

      // underrun with two words queued, timing=2
      in_valid = 1'b1;
      in_word = 16'h0031;
      step();
      in_word = 16'h0032;
      step();
      in_valid = 1'b0;
      timing = 32'd2;
      enable = 1'b1;
      step();
      step(); step(); step();
      chk("ur_first_strobe", word_strobe, 1);
      chk("ur_first_word", outputword, 16'h0031);
      chk("ur_first_index", wordIndex, 0);
      chk("ur_first_frame", frame_start, 1);
      step(); step(); step();
      chk("ur_second_word", outputword, 16'h0032);
      chk("ur_second_index", wordIndex, 1);
      chk("ur_second_frame", frame_start, 0);
      chk("ur_not_yet", underrun, 0);
      step(); step();
      clr_underrun = 1'b1;
      step();
      clr_underrun = 1'b0;
      chk("ur_set_wins", underrun, 1);
`ifdef SYSTOLIC_FEEDER_STALL_EN
      chk("stall_no_strobe", word_strobe, 0);
      chk("stall_index_hold", wordIndex, 1);
      repeat (4) step();
      in_valid = 1'b1;
      in_word = 16'h0033;
      step();
      in_valid = 1'b0;
      chk("stall_landing_strobe", word_strobe, 0);
      step();
      chk("stall_strobe", word_strobe, 1);
      chk("stall_word", outputword, 16'h0033);
      chk("stall_index", wordIndex, 2);
`else
      chk("zs_strobe", word_strobe, 1);
      chk("zs_word", outputword, 0);
      chk("zs_index", wordIndex, 2);
      chk("zs_frame", frame_start, 0);
`endif
      enable = 1'b0;
      step();
      chk("ur_sticky", underrun, 1);
      chk("ur_stop_index", wordIndex, 0);
      clr_underrun = 1'b1;
      step();
      clr_underrun = 1'b0;
      chk("ur_cleared", underrun, 0);

      // timing=0 gives one strobe per cycle
      in_valid = 1'b1;
      in_word = 16'h0041;
      step();
      in_word = 16'h0042;
      step();
      in_valid = 1'b0;
      timing = 32'd0;
      enable = 1'b1;
      step();
      step();
      chk("t0_strobe_a", word_strobe, 1);
      chk("t0_word_a", outputword, 16'h0041);
      chk("t0_index_a", wordIndex, 0);
      step();
      chk("t0_strobe_b", word_strobe, 1);
      chk("t0_word_b", outputword, 16'h0042);
      chk("t0_index_b", wordIndex, 1);
      enable = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Transmit-side sequencer for the systolic PE chain. It accepts samples from the upstream sampler over a valid/ready handshake and buffers them in a small FIFO. It releases one word every `timing`+1 clock cycles on `outputword`, together with a 3-bit slot index and strobes. This matches the per-slot pacing the PE array expects. It is the producer for the PE's `inputword`/`timing` receive path.

## Interface
- `WORDLENGTH`, 16, sample width in bits
- `DEPTH`, 8, FIFO depth in words; power of two, at least 2
- `clk30x`  in  1  sole clock
- `reset`  in  1  asynchronous, active-low reset
- `enable`  in  1  run request; level-sensitive
- `timing`  in  32  slot period minus one, in cycles
- `in_word`  in  WORDLENGTH  sample from upstream
- `in_valid`  in  1  `in_word` is valid
- `in_ready`  out  1  FIFO can accept; equals !full
- `outputword`  out  WORDLENGTH  word presented to the PE chain; registered
- `word_strobe`  out  1  one-cycle pulse when `outputword` updates
- `wordIndex`  out  3  slot index of the word currently presented, 0..7
- `frame_start`  out  1  pulse coincident with `word_strobe` when `wordIndex`==0
- `underrun`  out  1  sticky; a slot fired with the FIFO empty
- `clr_underrun`  in  1  synchronous clear of `underrun`
- `fill`  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- **Push:**
  - A push occurs when `in_valid` and `in_ready` are both high at a clock edge.
  - `in_ready` is combinational from `fill` (!full only). It does not look ahead to a same-cycle pop.
- **FSM states:** IDLE and RUN.
  - IDLE → RUN when `enable`=1. On that transition, `count` loads 0.
  - RUN → IDLE when `enable`=0. `count` and `wordIndex` clear to 0. FIFO contents are kept.
- **Slot counter:** `count` is 32 bits and increments each RUN cycle.
  - Terminal condition is `count` >= `timing`. The compare is unsigned.
  - This makes a `timing` decrease mid-slot end the slot at once; there is no 2^32 wrap.
- **Slot fire (terminal in RUN):**
  - `count` returns to 0.
  - If the FIFO is non-empty, pop: `outputword` is set to the FIFO head, `word_strobe` goes to 1, and `wordIndex` goes to `wordIndex`+1 (mod 8).
  - `frame_start` is asserted on the fire that produces `wordIndex`==0.
  - The first fire after reset or after RUN entry presents index 0.
- **Underrun (FIFO empty at fire):**
  - Sets `underrun`. The rest of the behaviour is set by the configuration macro (see Configuration).
- **Simultaneous events:**
  - Push and pop in the same cycle: `fill` is unchanged and data order is preserved.
  - `clr_underrun` in the same cycle as a new underrun: the set wins.
  - A push into an empty FIFO in the same cycle as a fire counts as underrun. There is no bypass.
- **Reset (any time, including mid-slot):**
  - All outputs go to 0 immediately, except `in_ready`, which is 1.
  - FIFO is emptied and the FSM goes to IDLE.

## Timing
- **First fire:** `enable` sampled high at edge E. The first `word_strobe` is at edge E+`timing`+1.
- **Subsequent fires:** every `timing`+1 cycles. `timing`=0 gives a strobe every cycle.
- **Latency:** a word pushed into an empty FIFO is eligible from the next edge. It appears on `outputword` at the first fire after that.
- **Output hold:** `outputword` and `wordIndex` stay stable between strobes. `word_strobe` and `frame_start` are single-cycle pulses.

## Configuration
- **`SYSTOLIC_FEEDER_STALL_EN` undefined (zero-stuff):**
  - On underrun, the fire proceeds with `outputword`=0.
  - `word_strobe` still pulses and `wordIndex` still advances.
- **`SYSTOLIC_FEEDER_STALL_EN` defined (stall):**
  - On underrun there is no strobe and `wordIndex` holds.
  - `count` holds at terminal, and the fire retries every cycle until the FIFO is non-empty.
  - The slot phase slips by the stall length.

## Structure
- **Package `systolic_pkg`:**
  - Default `WORDLENGTH`.
  - `TAPS`=8 and the index width of 3.
  - FSM state enum (IDLE, RUN).
- **Sub-module `feeder_fifo`:** synchronous FIFO, `DEPTH` × `WORDLENGTH`, pointer-based, with `fill`/full/empty outputs.
- **Top level:** FSM, slot counter, index counter and output registers.

## Test plan
- **Basic pacing:** `timing`=3; push 0x0011..0x0018; raise `enable` → strobes every 4 cycles, `wordIndex` 0..7, `frame_start` only on index 0, words in push order.
- **Backpressure:** `timing`=9; push 9 words back-to-back with `enable`=0 → `in_ready` drops after 8 accepted, `fill`=8, and the 9th word is held until the first pop.
- **Zero-stuff (macro undefined):** `timing`=2 with 2 words queued → third strobe carries 0x0000 at index 2, `underrun`=1 until `clr_underrun`.
- **Stall (macro defined):** same stimulus → no third strobe; a push 5 cycles later is presented at index 2 on the next edge after it lands.
- **Mid-run changes:**
  - Drop `timing` from 20 to 2 when `count`=10 → fire on the next edge.
  - Deassert `enable` → `wordIndex`=0 and `fill` is retained.
- **Async reset mid-slot:** assert `reset` low between edges → outputs 0 and `in_ready`=1 immediately; after release, the first strobe is at index 0.
